// File: rtl/mem_master.sv
`timescale 1ns/1ps
// Load/store unit bus master: turns one EX/MEM memory request into a single
// Wishbone classic cycle, stalling the pipeline until the cycle completes.
module mem_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32   // only 32 is supported
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,

    input  logic                  mem_en_i,
    input  logic                  mem_we_i,
    input  logic [1:0]            size_i,
    input  logic                  unsigned_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,

    output logic                  mem_stall_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  misalign_o,

    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    output logic                  wb_we_o,
    output logic [ADDR_WIDTH-1:0] wb_adr_o,
    output logic [DATA_WIDTH-1:0] wb_dat_o,
    output logic [3:0]            wb_sel_o,
    input  logic [DATA_WIDTH-1:0] wb_dat_i,
    input  logic                  wb_ack_i
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    state_t                state;
    logic                  aligned;
    logic [3:0]            sel_next;
    logic [DATA_WIDTH-1:0] wdata_shift;
    logic [DATA_WIDTH-1:0] load_shift;
    logic [DATA_WIDTH-1:0] load_ext;

    // Request attributes held for the load-data extension at ack time.
    logic [1:0]            offset_q;
    logic [1:0]            size_q;
    logic                  unsigned_q;

    // NOTE: every signal written in always_comb gets a value on every path
    // (defaults first), otherwise synthesis infers a latch.
    always_comb begin
        aligned  = 1'b0;
        sel_next = 4'b0000;
        case (size_i)
            SIZE_BYTE: begin
                aligned  = 1'b1;
                sel_next = 4'b0001 << addr_i[1:0];
            end
            SIZE_HALF: begin
                aligned  = ~addr_i[0];
                sel_next = 4'b0011 << addr_i[1:0];
            end
            SIZE_WORD: begin
                aligned  = (addr_i[1:0] == 2'b00);
                sel_next = 4'b1111;
            end
            default: begin
                aligned  = 1'b0;
                sel_next = 4'b0000;
            end
        endcase
        wdata_shift = wdata_i << {addr_i[1:0], 3'b000};
    end

    // Bus lanes come back word-aligned; move the addressed lane down, then extend.
    always_comb begin
        load_shift = wb_dat_i >> {offset_q, 3'b000};
        case (size_q)
            SIZE_BYTE: load_ext = {{(DATA_WIDTH-8){~unsigned_q & load_shift[7]}},
                                   load_shift[7:0]};
            SIZE_HALF: load_ext = {{(DATA_WIDTH-16){~unsigned_q & load_shift[15]}},
                                   load_shift[15:0]};
            default:   load_ext = load_shift;
        endcase
    end

    // Stall covers the request cycle itself; both flags are silent in reset.
    always_comb begin
        mem_stall_o = 1'b0;
        misalign_o  = 1'b0;
        if (rst_ni) begin
            mem_stall_o = (state == BUSY) ||
                          ((state == IDLE) && mem_en_i && aligned);
            misalign_o  = (state == IDLE) && mem_en_i && !aligned;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
            wb_we_o    <= 1'b0;
            wb_adr_o   <= '0;
            wb_dat_o   <= '0;
            wb_sel_o   <= 4'b0000;
            rdata_o    <= '0;
            offset_q   <= 2'b00;
            size_q     <= SIZE_BYTE;
            unsigned_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_en_i && aligned) begin
                        state      <= BUSY;
                        wb_cyc_o   <= 1'b1;
                        wb_stb_o   <= 1'b1;
                        wb_we_o    <= mem_we_i;
                        wb_adr_o   <= {addr_i[ADDR_WIDTH-1:2], 2'b00};
                        wb_dat_o   <= wdata_shift;
                        wb_sel_o   <= sel_next;
                        offset_q   <= addr_i[1:0];
                        size_q     <= size_i;
                        unsigned_q <= unsigned_i;
                    end
                end
                BUSY: begin
                    if (wb_ack_i) begin
                        state    <= DONE;
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        if (!wb_we_o) begin
                            rdata_o <= load_ext;
                        end
                    end
                end
                // One unstalled cycle lets the pipeline retire the held request.
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    wb_cyc_o <= 1'b0;
                    wb_stb_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_master.sv
`timescale 1ns/1ps
// Self-checking bench for mem_master: directed cases plus randomized
// transactions compared every cycle against a transaction-level model.
module tb_mem_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_en = 1'b0;
    logic        mem_we = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        uns = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        mem_stall;
    logic [31:0] rdata;
    logic        misalign;
    logic        wb_cyc, wb_stb, wb_we;
    logic [31:0] wb_adr, wb_dat_out;
    logic [3:0]  wb_sel;
    logic [31:0] wb_dat_in = '0;
    logic        wb_ack = 1'b0;

    always #5 clk = ~clk;

    mem_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .mem_en_i    (mem_en),
        .mem_we_i    (mem_we),
        .size_i      (size),
        .unsigned_i  (uns),
        .addr_i      (addr),
        .wdata_i     (wdata),
        .mem_stall_o (mem_stall),
        .rdata_o     (rdata),
        .misalign_o  (misalign),
        .wb_cyc_o    (wb_cyc),
        .wb_stb_o    (wb_stb),
        .wb_we_o     (wb_we),
        .wb_adr_o    (wb_adr),
        .wb_dat_o    (wb_dat_out),
        .wb_sel_o    (wb_sel),
        .wb_dat_i    (wb_dat_in),
        .wb_ack_i    (wb_ack)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    endtask

    // ---------------- reference model (transaction level) ----------------
    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit is_aligned(input logic [1:0] s, input logic [31:0] a);
        if (s == 2'd3) return 1'b0;
        return (int'(a[1:0]) % nbytes(s)) == 0;
    endfunction

    function automatic logic [3:0] model_sel(input logic [1:0] s, input logic [31:0] a);
        logic [3:0] m;
        m = 4'((1 << nbytes(s)) - 1);
        return m << a[1:0];
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] d, input logic [1:0] s,
                                               input logic [1:0] off, input logic u);
        logic [63:0] v, mask;
        int bits;
        bits = 8 * nbytes(s);
        v    = 64'(d >> (8 * off));
        mask = (64'd1 << bits) - 64'd1;
        v    = v & mask;
        if (!u && v[bits-1]) v = v | ~mask;
        return v[31:0];
    endfunction

    // Expected outputs for the current cycle, set by the driver from the model.
    bit          check_en = 1'b0;
    logic        exp_stall = 1'b0, exp_mis = 1'b0, exp_cyc = 1'b0, exp_we = 1'b0;
    logic [31:0] exp_adr = '0, exp_dat = '0, exp_rdata = '0;
    logic [3:0]  exp_sel = '0;

    always @(negedge clk) begin
        if (check_en) begin
            check("stall", {31'b0, mem_stall}, {31'b0, exp_stall});
            check("misalign", {31'b0, misalign}, {31'b0, exp_mis});
            check("cyc", {31'b0, wb_cyc}, {31'b0, exp_cyc});
            check("stb", {31'b0, wb_stb}, {31'b0, exp_cyc});
            check("rdata", rdata, exp_rdata);
            if (exp_cyc) begin
                check("adr", wb_adr, exp_adr);
                check("sel", {28'b0, wb_sel}, {28'b0, exp_sel});
                check("dat", wb_dat_out, exp_dat);
                check("we", {31'b0, wb_we}, {31'b0, exp_we});
            end
        end
    end

    // Per-transaction observations used by the literal checks.
    int          obs_stalls, obs_cycs;
    logic        obs_mis, obs_we;
    logic [3:0]  obs_sel;
    logic [31:0] obs_dat;

    task automatic end_cycle();
        @(negedge clk);
        if (mem_stall) obs_stalls++;
        if (misalign) obs_mis = 1'b1;
        if (wb_cyc) begin
            obs_cycs++;
            obs_sel = wb_sel;
            obs_dat = wb_dat_out;
            obs_we  = wb_we;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_inputs();
        mem_en = 1'($urandom);
        mem_we = 1'($urandom);
        size   = 2'($urandom);
        uns    = 1'($urandom);
        addr   = $urandom;
        wdata  = $urandom;
    endtask

    task automatic idle_cycle();
        scramble_inputs();
        mem_en    = 1'b0;
        wb_ack    = 1'b0;
        wb_dat_in = $urandom;
        exp_stall = 1'b0;
        exp_mis   = 1'b0;
        exp_cyc   = 1'b0;
        end_cycle();
    endtask

    // Called at posedge+1 with the DUT idle; returns in the same phase.
    task automatic run_txn(input logic [1:0] s, input logic [31:0] a, input logic we,
                           input logic u, input logic [31:0] wd, input logic [31:0] rd,
                           input int waits);
        bit ok;
        ok = is_aligned(s, a);
        obs_stalls = 0; obs_cycs = 0; obs_mis = 1'b0; obs_we = 1'b0;
        obs_sel = '0; obs_dat = '0;
        mem_en = 1'b1; mem_we = we; size = s; addr = a; wdata = wd; uns = u;
        wb_ack = 1'b0; wb_dat_in = $urandom;
        exp_stall = ok; exp_mis = !ok; exp_cyc = 1'b0;
        end_cycle();
        if (!ok) begin
            mem_en = 1'b0; exp_stall = 1'b0; exp_mis = 1'b0;
            return;
        end
        exp_cyc = 1'b1; exp_stall = 1'b1; exp_mis = 1'b0; exp_we = we;
        exp_adr = {a[31:2], 2'b00};
        exp_sel = model_sel(s, a);
        exp_dat = wd << (8 * a[1:0]);
        for (int i = 0; i <= waits; i++) begin
            scramble_inputs();
            wb_ack    = (i == waits);
            wb_dat_in = (i == waits) ? rd : $urandom;
            end_cycle();
        end
        if (!we) exp_rdata = model_load(rd, s, a[1:0], u);
        wb_ack = 1'b0; exp_cyc = 1'b0; exp_stall = 1'b0; exp_mis = 1'b0;
        scramble_inputs();
        end_cycle();
        mem_en = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [1:0]  s;
        logic [31:0] a;

        // Reset with a live aligned request and a stray ack on the inputs.
        mem_en = 1'b1; size = 2'd2; addr = 32'h0000_0100; wb_ack = 1'b1;
        #12;
        check("rst stall", {31'b0, mem_stall}, 32'd0);
        check("rst misalign", {31'b0, misalign}, 32'd0);
        check("rst cyc", {31'b0, wb_cyc}, 32'd0);
        check("rst stb", {31'b0, wb_stb}, 32'd0);
        check("rst we", {31'b0, wb_we}, 32'd0);
        check("rst adr", wb_adr, 32'd0);
        check("rst dat", wb_dat_out, 32'd0);
        check("rst sel", {28'b0, wb_sel}, 32'd0);
        check("rst rdata", rdata, 32'd0);
        mem_en = 1'b0; wb_ack = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_en = 1'b1;

        // Word load, two wait states.
        run_txn(2'd2, 32'h8000_0104, 1'b0, 1'b0, 32'h1111_2222, 32'hDEAD_BEEF, 2);
        check("word load sel", {28'b0, obs_sel}, 32'h0000_000F);
        check("word load stall cycles", obs_stalls, 32'd4);
        check("word load rdata", rdata, 32'hDEAD_BEEF);

        // Signed then unsigned byte load from the top lane.
        run_txn(2'd0, 32'h8000_0003, 1'b0, 1'b0, 32'h0, 32'h80FF_FF00, 0);
        check("lb sel", {28'b0, obs_sel}, 32'h0000_0008);
        check("lb rdata", rdata, 32'hFFFF_FF80);
        run_txn(2'd0, 32'h8000_0003, 1'b0, 1'b1, 32'h0, 32'h80FF_FF00, 0);
        check("lbu rdata", rdata, 32'h0000_0080);

        // Half store on the upper lanes leaves rdata alone.
        run_txn(2'd1, 32'h8000_0002, 1'b1, 1'b0, 32'h0000_1234, 32'hCAFE_F00D, 1);
        check("sh sel", {28'b0, obs_sel}, 32'h0000_000C);
        check("sh dat", obs_dat, 32'h1234_0000);
        check("sh we", {31'b0, obs_we}, 32'd1);
        check("sh rdata kept", rdata, 32'h0000_0080);

        // Reset pulse while BUSY, before any ack.
        mem_en = 1'b1; mem_we = 1'b0; size = 2'd2; addr = 32'h8000_0010;
        exp_stall = 1'b1; exp_mis = 1'b0; exp_cyc = 1'b0;
        end_cycle();
        check_en = 1'b0;
        mem_en = 1'b0; wb_ack = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("busy rst cyc", {31'b0, wb_cyc}, 32'd0);
        check("busy rst stb", {31'b0, wb_stb}, 32'd0);
        check("busy rst stall", {31'b0, mem_stall}, 32'd0);
        check("busy rst rdata", rdata, 32'd0);
        #1 rst_n = 1'b1;
        exp_rdata = '0; exp_stall = 1'b0; exp_mis = 1'b0; exp_cyc = 1'b0;
        check_en = 1'b1;
        wb_ack = 1'b1;
        wb_dat_in = 32'h5555_AAAA;
        obs_cycs = 0;
        end_cycle();
        end_cycle();
        check("no resume after rst", obs_cycs, 32'd0);
        wb_ack = 1'b0;

        // Misaligned word: flagged, no stall, no bus cycle.
        run_txn(2'd2, 32'h8000_0001, 1'b0, 1'b0, 32'h0, 32'h0, 0);
        check("misaligned flag", {31'b0, obs_mis}, 32'd1);
        check("misaligned stall cycles", obs_stalls, 32'd0);
        check("misaligned bus cycles", obs_cycs, 32'd0);
        idle_cycle();

        // Back-to-back loads with immediate ack.
        run_txn(2'd2, 32'h0000_0040, 1'b0, 1'b0, 32'h0, 32'h0102_0304, 0);
        check("b2b #1 stall cycles", obs_stalls, 32'd2);
        check("b2b #1 bus cycles", obs_cycs, 32'd1);
        run_txn(2'd1, 32'h0000_0046, 1'b0, 1'b0, 32'h0, 32'h8765_4321, 0);
        check("b2b #2 stall cycles", obs_stalls, 32'd2);
        check("b2b #2 bus cycles", obs_cycs, 32'd1);
        check("b2b #2 rdata", rdata, 32'hFFFF_8765);

        // Randomized traffic.
        for (int n = 0; n < 300; n++) begin
            s = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (s == 2'd1) a[0] = 1'b0;
                if (s == 2'd2) a[1:0] = 2'b00;
            end
            run_txn(s, a, 1'($urandom), 1'($urandom), $urandom, $urandom,
                    int'($urandom_range(0, 3)));
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end
        idle_cycle();
        check_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
